mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter AW, default 16, address width.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter MIN_WAIT, default 0, number of ACC cycles during which mem_ready is ignored.
REQ-004 Parameter TIMEOUT, default 255, number of ACC cycles before the access is aborted; must exceed MIN_WAIT.
REQ-005 Parameter USR_LO, default 16'h3000, lowest address a user-mode access may reach.
REQ-006 Parameter USR_HI, default 16'hFDFF, highest address a user-mode access may reach.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 req_vld  in  1  request valid.
REQ-010 req_rdy  out  1  sequencer can accept a request.
REQ-011 req_we  in  1  1 = write, 0 = read.
REQ-012 req_addr  in  AW  access address.
REQ-013 req_wdata  in  DW  write data.
REQ-014 req_usr  in  1  requester privilege, 1 = user mode (PSR[15]).
REQ-015 rsp_vld  out  1  one-cycle response strobe.
REQ-016 rsp_rdata  out  DW  read data.
REQ-017 rsp_acv  out  1  access-control violation.
REQ-018 rsp_tmo  out  1  access timed out.
REQ-019 mem_en  out  1  memory enable.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  AW  memory address.
REQ-022 mem_wdata  out  DW  memory write data.
REQ-023 mem_rdata  in  DW  memory read data.
REQ-024 mem_ready  in  1  memory completion.

Function
REQ-025 The FSM SHALL have four states: IDLE, CHK, ACC, RSP.
REQ-026 IDLE: req_rdy=1; when req_vld=1, latch we/addr/wdata/usr and go to CHK; otherwise stay.
REQ-027 CHK: acv = latched usr & (addr<USR_LO | addr>USR_HI); acv=1 -> RSP with rsp_acv=1 and no memory access; acv=0 -> ACC with the wait counter cleared.
REQ-028 ACC: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, all held stable; wait counter increments by 1 each cycle.
REQ-029 ACC: mem_ready=1 with counter>=MIN_WAIT -> capture mem_rdata (reads only) and go to RSP.
REQ-030 ACC: counter==TIMEOUT-1 without a qualifying mem_ready -> go to RSP with rsp_tmo=1. If both conditions hit in the same cycle, mem_ready wins and tmo=0.
REQ-031 RSP: rsp_vld=1 for exactly one cycle, then IDLE; req_rdy=0 in CHK, ACC and RSP.
REQ-032 rsp_rdata SHALL be 0 for writes, ACV and timeout.
REQ-033 rsp_acv and rsp_tmo are never both 1.
REQ-034 rsp_rdata, rsp_acv and rsp_tmo are valid only while rsp_vld=1 and SHALL be 0 otherwise.
REQ-035 Minimum latency from acceptance edge to rsp_vld: 3 cycles with mem_ready=1 and MIN_WAIT=0; 2 cycles for ACV.
REQ-036 Back-to-back: a req_vld held through RSP is accepted in the following IDLE cycle; no request is accepted while busy.
REQ-037 mem_en, mem_we, mem_addr and mem_wdata SHALL be 0 outside ACC.
REQ-038 The wait counter is ceil(log2(TIMEOUT+1)) bits wide and never wraps.

Reset
REQ-039 rst_n=0 SHALL asynchronously force IDLE, clear the counter and latches, and drive every output to 0 except req_rdy, which goes to 1.
REQ-040 Reset mid-ACC SHALL drop mem_en immediately and produce no rsp_vld for the aborted request.

Structure
REQ-041 A shared package SHALL hold the state encoding (2-bit) and the default USR_LO/USR_HI constants.
REQ-042 mem_seq SHALL be a single module; the address-range check may be one sub-module, acv_chk.

Verification
REQ-043 User read of 16'h3000, mem_ready=1 in the first ACC cycle, mem_rdata=16'hBEEF -> rsp_vld 3 cycles after acceptance, rsp_rdata=16'hBEEF, acv=0, tmo=0.
REQ-044 User write to 16'h2FFF -> mem_en never asserts; rsp_vld 2 cycles after acceptance with rsp_acv=1; the same access in supervisor mode completes normally.
REQ-045 MIN_WAIT=2, mem_ready held at 1 -> data is captured on the 3rd ACC cycle and mem_ready is ignored in ACC cycles 1-2.
REQ-046 TIMEOUT=8, mem_ready=0 -> rsp_tmo=1 after 8 ACC cycles; a second run with mem_ready=1 exactly on the 8th cycle gives tmo=0 and valid data.
REQ-047 Reset asserted in the 3rd ACC cycle -> mem_en=0 asynchronously, no rsp_vld, req_rdy=1 after release.
REQ-048 req_vld held continuously for 3 requests -> each request is accepted in IDLE only, rsp_vld pulses once per request, and no request is lost.

Source files
------------

// File: rtl/mem_seq_pkg.sv
//==============================================================================
// Module      : mem_seq_pkg
// Description : Shared state encoding and default user-address window for
//               the memory access sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHK  = 2'd1,
        ST_ACC  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [15:0] c_USR_LO_DEFAULT = 16'h3000;
    localparam logic [15:0] c_USR_HI_DEFAULT = 16'hFDFF;

endpackage

`default_nettype wire

// File: rtl/mem_seq_acv_chk.sv
//==============================================================================
// Module      : acv_chk
// Description : Flags a user-mode access that falls outside the user window.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module acv_chk
    import mem_seq_pkg::*;
#(
    parameter int            AW     = 16,
    parameter logic [AW-1:0] USR_LO = AW'(c_USR_LO_DEFAULT),
    parameter logic [AW-1:0] USR_HI = AW'(c_USR_HI_DEFAULT)
) (
    input  logic          usr,
    input  logic [AW-1:0] addr,
    output logic          acv
);

    assign acv = usr & ((addr < USR_LO) | (addr > USR_HI));

endmodule

`default_nettype wire

// File: rtl/mem_seq.sv
//==============================================================================
// Module      : mem_seq
// Description : Single-outstanding memory access sequencer with privilege
//               check, minimum-wait qualification and access timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter int            MIN_WAIT = 0,
    parameter int            TIMEOUT  = 255,
    parameter logic [AW-1:0] USR_LO   = AW'(c_USR_LO_DEFAULT),
    parameter logic [AW-1:0] USR_HI   = AW'(c_USR_HI_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          req_usr,
    output logic          rsp_vld,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_acv,
    output logic          rsp_tmo,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int              c_CW       = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic            r_usr;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_acv;
    logic            r_tmo;
    logic [c_CW-1:0] r_cnt;

    logic            w_acv;
    logic            w_wait_ok;
    logic            w_done;
    logic            w_tmo;

    acv_chk #(
        .AW     (AW),
        .USR_LO (USR_LO),
        .USR_HI (USR_HI)
    ) u_acv_chk (
        .usr  (r_usr),
        .addr (r_addr),
        .acv  (w_acv)
    );

    // With no minimum wait the qualification is unconditional; spelling it out
    // avoids a constant unsigned >= 0 comparison.
    generate
        if (MIN_WAIT == 0) begin : g_no_min_wait
            assign w_wait_ok = 1'b1;
        end else begin : g_min_wait
            assign w_wait_ok = (r_cnt >= c_CW'(MIN_WAIT));
        end
    endgenerate

    assign w_done = (r_state == ST_ACC) && mem_ready && w_wait_ok;
    assign w_tmo  = (r_state == ST_ACC) && !w_done && (r_cnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_usr   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_acv   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_vld) begin
                        r_we    <= req_we;
                        r_usr   <= req_usr;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end
                end
                ST_CHK: begin
                    r_cnt   <= '0;
                    r_acv   <= w_acv;
                    r_tmo   <= 1'b0;
                    r_rdata <= '0;
                end
                ST_ACC: begin
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                    if (w_done && !r_we) begin
                        r_rdata <= mem_rdata;
                    end
                    r_tmo <= w_tmo;
                end
                default: begin
                    r_acv   <= 1'b0;
                    r_tmo   <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    // Outputs decode from state so reset silences the memory port immediately.
    always_comb begin
        w_next    = r_state;
        req_rdy   = 1'b0;
        rsp_vld   = 1'b0;
        rsp_rdata = '0;
        rsp_acv   = 1'b0;
        rsp_tmo   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    w_next = ST_CHK;
                end
            end
            ST_CHK: begin
                w_next = w_acv ? ST_RSP : ST_ACC;
            end
            ST_ACC: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (w_done || w_tmo) begin
                    w_next = ST_RSP;
                end
            end
            default: begin
                rsp_vld   = 1'b1;
                rsp_rdata = r_rdata;
                rsp_acv   = r_acv;
                rsp_tmo   = r_tmo & ~r_acv;
                w_next    = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_seq.sv
//==============================================================================
// Module      : tb_mem_seq
// Description : Directed self-checking bench for mem_seq (default build and a
//               MIN_WAIT=2 / TIMEOUT=8 build sharing the request bus).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld_a, req_vld_b;
    logic        req_we, req_usr;
    logic [15:0] req_addr, req_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    logic        rdy_a, vld_a, acv_a, tmo_a, en_a, we_a;
    logic [15:0] rdata_a, addr_a, wdata_a;
    logic        rdy_b, vld_b, acv_b, tmo_b, en_b, we_b;
    logic [15:0] rdata_b, addr_b, wdata_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_seq dut_a (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld_a), .req_rdy(rdy_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_usr(req_usr),
        .rsp_vld(vld_a), .rsp_rdata(rdata_a), .rsp_acv(acv_a), .rsp_tmo(tmo_a),
        .mem_en(en_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_seq #(.MIN_WAIT(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld_b), .req_rdy(rdy_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_usr(req_usr),
        .rsp_vld(vld_b), .rsp_rdata(rdata_b), .rsp_acv(acv_b), .rsp_tmo(tmo_b),
        .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it to its response. ready_at>0 drives
    // mem_ready high only in that ACC cycle; ready_at==0 leaves mem_ready alone.
    task automatic run_req(input bit b, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic usr, input int ready_at,
                           output int lat, output int en_cnt, output logic [15:0] rdata,
                           output logic acv, output logic tmo, output logic [15:0] s_addr,
                           output logic [15:0] s_wdata, output logic s_we);
        bit done = 0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_usr = usr;
        if (ready_at > 0) mem_ready = 1'b0;
        if (b) req_vld_b = 1'b1; else req_vld_a = 1'b1;
        @(negedge clk);
        req_vld_a = 1'b0; req_vld_b = 1'b0;
        lat = -1; en_cnt = 0; rdata = '0; acv = 0; tmo = 0;
        s_addr = '0; s_wdata = '0; s_we = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (k > 1) @(negedge clk);
            if (b ? en_b : en_a) begin
                en_cnt++;
                s_addr  = b ? addr_b : addr_a;
                s_wdata = b ? wdata_b : wdata_a;
                s_we    = b ? we_b : we_a;
                if (ready_at > 0) mem_ready = (en_cnt == ready_at);
            end
            if (b ? vld_b : vld_a) begin
                done  = 1;
                lat   = k;
                rdata = b ? rdata_b : rdata_a;
                acv   = b ? acv_b : acv_a;
                tmo   = b ? tmo_b : tmo_a;
            end
        end
        @(negedge clk);
        if (b) chk("rsp_clear_b", {rdy_b, vld_b, acv_b, tmo_b, rdata_b}, {4'b1000, 16'h0});
        else   chk("rsp_clear_a", {rdy_a, vld_a, acv_a, tmo_a, rdata_a}, {4'b1000, 16'h0});
    endtask

    int          lat, en_cnt;
    logic [15:0] rdata, s_addr, s_wdata;
    logic        acv, tmo, s_we;
    logic [15:0] b2b_addr [3];
    int          n_acc, n_rsp, last_rsp;
    bit          seen_vld;

    initial begin
        rst_n = 1'b0; req_vld_a = 0; req_vld_b = 0; req_we = 0; req_usr = 0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 0;
        @(negedge clk);
        chk("reset_a", {rdy_a, vld_a, acv_a, tmo_a, en_a, we_a}, 6'b100000);
        chk("reset_a_bus", {rdata_a, addr_a, wdata_a}, 48'h0);
        chk("reset_b", {rdy_b, vld_b, en_b, addr_b}, {3'b100, 16'h0});
        rst_n = 1'b1;
        @(negedge clk);

        // User read at the bottom of the window
        mem_ready = 1; mem_rdata = 16'hBEEF;
        run_req(0, 0, 16'h3000, 16'h0, 1, 0, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("urd_lat", lat, 3);
        chk("urd_en", en_cnt, 1);
        chk("urd_rsp", {acv, tmo, rdata}, {2'b00, 16'hBEEF});
        chk("urd_addr", {s_we, s_addr}, {1'b0, 16'h3000});

        // User write just below the window: violation, no memory access
        mem_rdata = 16'hFFFF;
        run_req(0, 1, 16'h2FFF, 16'h1234, 1, 0, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("uwr_acv_lat", lat, 2);
        chk("uwr_acv_en", en_cnt, 0);
        chk("uwr_acv_rsp", {acv, tmo, rdata}, {2'b10, 16'h0});

        // Same write in supervisor mode completes, read data forced to 0
        run_req(0, 1, 16'h2FFF, 16'h1234, 0, 0, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("swr_lat", lat, 3);
        chk("swr_rsp", {acv, tmo, rdata}, {2'b00, 16'h0});
        chk("swr_bus", {s_we, s_addr, s_wdata}, {1'b1, 16'h2FFF, 16'h1234});

        // Top of the window and one past it
        mem_rdata = 16'h0A0A;
        run_req(0, 0, 16'hFDFF, 16'h0, 1, 0, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("uhi_ok", {lat[3:0], acv, tmo, rdata}, {4'd3, 2'b00, 16'h0A0A});
        run_req(0, 0, 16'hFE00, 16'h0, 1, 0, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("uhi_acv", {lat[3:0], en_cnt[3:0], acv, tmo, rdata}, {4'd2, 4'd0, 2'b10, 16'h0});

        // MIN_WAIT=2 with mem_ready held: captured on 3rd ACC cycle
        mem_ready = 1; mem_rdata = 16'hCAFE;
        run_req(1, 0, 16'h4000, 16'h0, 0, 0, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("minw_lat", lat, 5);
        chk("minw_en", en_cnt, 3);
        chk("minw_rsp", {acv, tmo, rdata}, {2'b00, 16'hCAFE});

        // TIMEOUT=8, never ready
        run_req(1, 0, 16'h4002, 16'h0, 0, 99, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("tmo_lat", lat, 10);
        chk("tmo_en", en_cnt, 8);
        chk("tmo_rsp", {acv, tmo, rdata}, {2'b01, 16'h0});

        // Ready exactly in the 8th ACC cycle wins over timeout
        mem_rdata = 16'h1357;
        run_req(1, 0, 16'h4004, 16'h0, 0, 8, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("tmo_edge_lat", lat, 10);
        chk("tmo_edge_rsp", {acv, tmo, rdata}, {2'b00, 16'h1357});

        // Ready only in ACC cycle 2 is ignored under MIN_WAIT=2
        run_req(1, 0, 16'h4006, 16'h0, 0, 2, lat, en_cnt, rdata, acv, tmo, s_addr, s_wdata, s_we);
        chk("early_rdy_rsp", {lat[7:0], acv, tmo, rdata}, {8'd10, 2'b01, 16'h0});

        // Reset in the 3rd ACC cycle
        mem_ready = 0;
        req_we = 0; req_addr = 16'h5000; req_usr = 0; req_vld_a = 1;
        @(negedge clk);
        req_vld_a = 0;
        repeat (3) @(negedge clk);
        chk("rst_pre_en", en_a, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {en_a, addr_a, rdy_a, vld_a}, {1'b0, 16'h0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1;
        seen_vld = 0;
        repeat (5) begin
            @(negedge clk);
            if (vld_a) seen_vld = 1;
        end
        chk("rst_no_rsp", {seen_vld, rdy_a}, 2'b01);

        // Three back-to-back requests with req_vld held
        b2b_addr[0] = 16'h6000; b2b_addr[1] = 16'h6010; b2b_addr[2] = 16'h6020;
        n_acc = 0; n_rsp = 0; last_rsp = 0;
        req_we = 0; req_usr = 1;
        for (int cyc = 1; cyc <= 40 && n_rsp < 3; cyc++) begin
            mem_rdata = addr_a ^ 16'h5A5A;
            if (vld_a) begin
                chk("b2b_data", rdata_a, b2b_addr[n_rsp] ^ 16'h5A5A);
                if (n_rsp > 0) chk("b2b_spacing", cyc - last_rsp, 4);
                last_rsp = cyc;
                n_rsp++;
            end
            if (rdy_a) begin
                req_vld_a = (n_acc < 3);
                if (n_acc < 3) begin
                    req_addr = b2b_addr[n_acc];
                    n_acc++;
                end
            end
            @(negedge clk);
        end
        req_vld_a = 0;
        chk("b2b_counts", {n_acc[3:0], n_rsp[3:0]}, {4'd3, 4'd3});
        @(negedge clk);
        chk("b2b_idle", {rdy_a, vld_a}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
